uart_tx_arbiter: RTL

//  Shares the board's single UART transmit line (RsTx) among NUM_REQ byte-stream requesters.

---
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter feeding a single UART serializer (8N1).
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1, 11-bit frames).
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int CLKS_PER_BIT = 10417,
  parameter int HOLD_BITS    = 16
) (
  input  logic                 clk,
  input  logic                 btnC,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx,
  output logic                 busy
);
  localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HLIM = HOLD_BITS * CLKS_PER_BIT;
  localparam int HW   = $clog2(HLIM + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP,
    HOLD
  } state_t;

  state_t          state, state_d;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            last_q;
  logic [HW-1:0]   hold_cnt;
  logic [PW-1:0]   owner, rr_ptr, pick, idx, acc_idx, nxt_ptr;
  logic            pick_any, accept, bit_end, rel;

  assign bit_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign nxt_ptr = (NUM_REQ == 1 || owner == PW'(NUM_REQ - 1)) ? '0 : owner + PW'(1);
  assign rel     = (state != IDLE) && (state_d == IDLE);

  // first valid requester at or above rr_ptr, wrapping
  always_comb begin
    pick     = rr_ptr;
    pick_any = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!pick_any && req_valid[idx]) begin
        pick_any = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    acc_idx = owner;
    case (state)
      IDLE:  if (pick_any) begin
               accept  = 1'b1;
               acc_idx = pick;
               state_d = START;
             end
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
             end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP:  if (bit_end) state_d = last_q ? IDLE : HOLD;
      // owner valid wins over a coincident timeout
      HOLD:  if (req_valid[owner]) begin
               accept  = 1'b1;
               state_d = START;
             end else if (hold_cnt == HW'(HLIM - 1)) begin
               state_d = IDLE;
             end
      default: state_d = IDLE;
    endcase
    req_ready = (accept && !btnC) ? (NUM_REQ'(1) << acc_idx) : '0;
  end

  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    case (state)
      START:  tx = 1'b0;
      DATA:   tx = shreg[bit_cnt];
`ifdef UART_TX_PARITY_EN
      PARITY: tx = ^shreg;
`endif
      STOP:   tx = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      last_q   <= 1'b0;
      owner    <= '0;
      rr_ptr   <= '0;
      grant    <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        shreg  <= req_data[{acc_idx, 3'b000} +: 8];
        last_q <= req_last[acc_idx];
        owner  <= acc_idx;
        grant  <= NUM_REQ'(1) << acc_idx;
      end else if (rel) begin
        grant  <= '0;
        rr_ptr <= nxt_ptr;
      end
      if (busy && !bit_end) baud_cnt <= baud_cnt + BW'(1);
      else                  baud_cnt <= '0;
      if (state == DATA && bit_end) bit_cnt <= bit_cnt + 3'd1;
      if (state == HOLD && !accept) begin
        if (hold_cnt != HW'(HLIM)) hold_cnt <= hold_cnt + HW'(1);
      end else begin
        hold_cnt <= '0;
      end
    end
  end
endmodule
